// File: rtl/bht_scheduler.sv
// bht_scheduler: 2-bit saturating-counter branch history table with
// post-reset initialisation and an in-order queue of open predictions.
module bht_scheduler #(
   parameter int INDEX_BITS = 4,
   parameter int DEPTH      = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   input  logic [INDEX_BITS-1:0]   req_index,
   output logic                    req_ready,
   output logic                    pred_valid,
   output logic                    pred_taken,
   output logic [INDEX_BITS-1:0]   pred_index,
   input  logic                    resolve_valid,
   input  logic                    resolve_taken,
   output logic                    mispredict,
   output logic [$clog2(DEPTH):0]  outstanding,
   output logic                    full,
   output logic                    err
);

   localparam int ENTRIES = 1 << INDEX_BITS;
   localparam int PW      = $clog2(DEPTH);
   localparam int CW      = PW + 1;

   localparam logic [0:0] S_INIT = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam logic [CW-1:0]         CNT_MAX = CW'(DEPTH);
   localparam logic [INDEX_BITS-1:0] LAST    = INDEX_BITS'(ENTRIES - 1);

   logic [0:0]            state;
   logic [INDEX_BITS-1:0] init_ptr;
   logic [1:0]            ctr   [ENTRIES];
   logic [INDEX_BITS-1:0] q_idx [DEPTH];
   logic                  q_p   [DEPTH];
   logic [PW-1:0]         head;
   logic [PW-1:0]         tail;
   logic [CW-1:0]         count;
   logic [CW-1:0]         count_nxt;

   logic                  running;
   logic                  init_done;
   logic                  accept;
   logic                  pop;
   logic                  bad_resolve;
   logic [INDEX_BITS-1:0] upd_idx;
   logic [1:0]            upd_old;
   logic [1:0]            upd_new;

   // Handshake qualification, saturating update and next queue count.
   always_comb begin
      running     = (state == S_RUN);
      init_done   = (state == S_INIT) && (init_ptr == LAST);
      accept      = running && req_valid && req_ready;
      pop         = running && resolve_valid && (count != '0);
      bad_resolve = resolve_valid && !pop;
      upd_idx     = q_idx[head];
      upd_old     = ctr[upd_idx];
      upd_new     = upd_old;
      if (resolve_taken) begin
         if (upd_old != 2'b11) upd_new = upd_old + 2'd1;
      end else begin
         if (upd_old != 2'b00) upd_new = upd_old - 2'd1;
      end
      count_nxt = count;
      if (accept && !pop)
         count_nxt = count + CW'(1);
      else if (pop && !accept)
         count_nxt = count - CW'(1);
   end

   // Control state, queue pointers and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_INIT;
         init_ptr   <= '0;
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         req_ready  <= 1'b0;
         pred_valid <= 1'b0;
         pred_taken <= 1'b0;
         pred_index <= '0;
         mispredict <= 1'b0;
         err        <= 1'b0;
      end else begin
         if (state == S_INIT) begin
            init_ptr <= init_ptr + INDEX_BITS'(1);
            if (init_done) state <= S_RUN;
         end
         if (accept) tail <= tail + PW'(1);
         if (pop)    head <= head + PW'(1);
         count      <= count_nxt;
         // Ready follows the post-edge count, so a pop while full
         // only re-opens the port from the next cycle.
         req_ready  <= (running || init_done) && (count_nxt != CNT_MAX);
         pred_valid <= accept;
         if (accept) begin
            pred_taken <= ctr[req_index][1];
            pred_index <= req_index;
         end
         mispredict <= pop && (resolve_taken != q_p[head]);
         if (bad_resolve) err <= 1'b1;
      end
   end

   // Counter table and queue storage; reads see pre-update values.
   always_ff @(posedge clk) begin
      if (!rst && state == S_INIT)
         ctr[init_ptr] <= 2'b11;
      else if (!rst && pop)
         ctr[upd_idx] <= upd_new;
      if (!rst && accept) begin
         q_idx[tail] <= req_index;
         q_p[tail]   <= ctr[req_index][1];
      end
   end

   assign outstanding = count;
   assign full        = (count == CNT_MAX);

endmodule

// File: tb/tb_bht_scheduler.sv
// tb_bht_scheduler: directed and random stimulus against a queue/array
// reference model, with per-cycle and per-prediction scoreboards.
module tb_bht_scheduler;

   localparam int IB = 4;
   localparam int D  = 4;
   localparam int N  = 1 << IB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [IB-1:0] req_index = '0;
   logic          resolve_valid = 1'b0;
   logic          resolve_taken = 1'b0;
   logic          req_ready;
   logic          pred_valid;
   logic          pred_taken;
   logic [IB-1:0] pred_index;
   logic          mispredict;
   logic [2:0]    outstanding;
   logic          full;
   logic          err;

   bht_scheduler #(.INDEX_BITS(IB), .DEPTH(D)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_index(req_index),
      .req_ready(req_ready),
      .pred_valid(pred_valid), .pred_taken(pred_taken),
      .pred_index(pred_index),
      .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
      .mispredict(mispredict), .outstanding(outstanding),
      .full(full), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IB-1:0] idx;
      logic          p;
   } pred_t;

   typedef struct {
      logic ready;
      int   outst;
      logic full;
      logic err;
      logic mis;
   } cyc_t;

   pred_t exp_pred[$];
   cyc_t  exp_cyc[$];

   int    m_ctr[N];
   bit    m_run;
   int    m_ptr;
   bit    m_ready;
   bit    m_err;
   pred_t m_q[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference behaviour for one clock edge, from the current inputs.
   task automatic model_step();
      cyc_t  e;
      pred_t p;
      pred_t h;
      bit    acc;
      bit    mis;
      mis = 1'b0;
      if (rst) begin
         m_run   = 1'b0;
         m_ptr   = 0;
         m_q.delete();
         m_ready = 1'b0;
         m_err   = 1'b0;
      end else if (!m_run) begin
         m_ctr[m_ptr] = 3;
         if (resolve_valid) m_err = 1'b1;
         if (m_ptr == N - 1) m_run = 1'b1;
         m_ptr = (m_ptr + 1) % N;
         m_ready = m_run && (m_q.size() < D);
      end else begin
         acc = req_valid && m_ready;
         if (acc) begin
            p.idx = req_index;
            p.p   = (m_ctr[req_index] >= 2);
            exp_pred.push_back(p);
         end
         if (resolve_valid) begin
            if (m_q.size() == 0) begin
               m_err = 1'b1;
            end else begin
               h   = m_q.pop_front();
               mis = (resolve_taken != h.p);
               if (resolve_taken)
                  m_ctr[h.idx] = (m_ctr[h.idx] == 3) ? 3 : m_ctr[h.idx] + 1;
               else
                  m_ctr[h.idx] = (m_ctr[h.idx] == 0) ? 0 : m_ctr[h.idx] - 1;
            end
         end
         if (acc) m_q.push_back(p);
         m_ready = (m_q.size() < D);
      end
      e.ready = m_ready;
      e.outst = m_q.size();
      e.full  = (m_q.size() == D);
      e.err   = m_err;
      e.mis   = mis;
      exp_cyc.push_back(e);
   endtask

   task automatic step(input bit r, input bit rv, input int ri,
                       input bit sv, input bit st);
      rst           = r;
      req_valid     = rv;
      req_index     = ri[IB-1:0];
      resolve_valid = sv;
      resolve_taken = st;
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic do_req(input int i);
      step(0, 1, i, 0, 0);
   endtask

   task automatic do_res(input bit t);
      step(0, 0, 0, 1, t);
   endtask

   // Monitor: per-cycle status plus prediction scoreboard on pred_valid.
   always @(negedge clk) begin
      cyc_t  e;
      pred_t p;
      if (exp_cyc.size() > 0) begin
         e = exp_cyc.pop_front();
         chk("req_ready", int'(req_ready), int'(e.ready));
         chk("outstanding", int'(outstanding), e.outst);
         chk("full", int'(full), int'(e.full));
         chk("err", int'(err), int'(e.err));
         chk("mispredict", int'(mispredict), int'(e.mis));
      end
      if (pred_valid) begin
         if (exp_pred.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pred_unexpected actual=1 expected=0 at %0t", $time);
         end else begin
            p = exp_pred.pop_front();
            chk("pred_taken", int'(pred_taken), int'(p.p));
            chk("pred_index", int'(pred_index), int'(p.idx));
         end
      end
   end

   initial begin
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      idle(17);

      do_req(5);
      idle(1);
      do_res(0);
      do_req(5);
      do_res(0);
      do_req(5);
      idle(2);
      do_res(1);

      do_req(1);
      do_req(2);
      do_req(4);
      do_req(6);
      do_req(8);
      do_res(1);
      do_req(9);
      idle(1);
      for (int i = 0; i < 4; i++) do_res(1);

      do_req(3);
      do_res(0);
      do_req(3);
      step(0, 1, 3, 1, 0);
      do_res(0);
      do_req(3);
      do_res(0);

      do_res(1);
      idle(2);
      for (int i = 0; i < 5; i++) begin
         do_req(7);
         do_res(1);
      end

      do_req(2);
      do_req(3);
      step(1, 0, 0, 0, 0);
      idle(17);
      for (int i = 0; i < N; i++) begin
         do_req(i);
         do_res(1);
      end

      step(1, 0, 0, 0, 0);
      do_res(1);
      idle(17);

      for (int c = 0; c < 3000; c++) begin
         step(($urandom % 500) == 0,
              ($urandom % 2) == 0,
              int'($urandom % N),
              ($urandom % 2) == 0,
              ($urandom % 2) == 0);
      end

      idle(3);
      @(negedge clk);
      #1;
      chk("pred_drain", exp_pred.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bht_scheduler.md
# bht_scheduler

Branch-history-table controller that owns a table of 2-bit saturating counters and sequences access to it for the fetch and execute stages. It accepts prediction requests indexed by low PC bits and tracks outstanding predictions in an in-order queue. It applies resolved outcomes to the counter that produced each prediction and flags mispredictions. It also runs a multi-cycle table initialisation after reset.

## Interface

- INDEX_BITS, 4, table index width; table has 2^INDEX_BITS counters
- DEPTH, 4, max outstanding (unresolved) predictions; power of two, ≥2

- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  prediction request
- req_index  in  INDEX_BITS  table index for the request
- req_ready  out  1  request accepted when req_valid && req_ready
- pred_valid  out  1  one-cycle pulse, prediction available
- pred_taken  out  1  predicted direction (counter MSB)
- pred_index  out  INDEX_BITS  echo of accepted req_index
- resolve_valid  in  1  oldest outstanding branch resolved
- resolve_taken  in  1  actual direction
- mispredict  out  1  one-cycle pulse, resolved outcome ≠ prediction
- outstanding  out  $clog2(DEPTH)+1  queued predictions
- full  out  1  outstanding == DEPTH
- err  out  1  sticky: resolve with nothing outstanding or during INIT

## Operation

- States: INIT, RUN.
- rst high: state INIT, init pointer 0, queue empty. All outputs 0 (req_ready, pred_*, mispredict, outstanding, full, err).
- INIT:
  - Each cycle with rst low writes 2'b11 (strongly taken) to entry[init pointer] and increments the pointer.
  - After entry 2^INDEX_BITS−1 is written, state becomes RUN.
  - req_ready = 0 throughout INIT.
  - resolve_valid in INIT sets err; no other effect.
- RUN:
  - req_ready = !full. A request while full is not accepted and has no effect.
  - Accepted request:
    - pred_taken ← entry[req_index][1]; pred_index ← req_index; pred_valid pulses next cycle.
    - {req_index, predicted bit} pushed to queue tail.
  - resolve_valid with outstanding > 0:
    - Pop queue head {idx, p}.
    - entry[idx] saturating update: taken → min(c+1, 3); not taken → max(c−1, 0). No wrap at 3 or 0.
    - mispredict ← (resolve_taken != p).
  - resolve_valid with outstanding == 0: err ← 1; table and queue unchanged.
  - Same-cycle accept and resolve:
    - Push and pop both occur; outstanding unchanged.
    - If full, the resolve does not make req_ready high in that same cycle (req_ready is registered from the current count).
  - Same-cycle request read and resolve write to the same entry: the prediction uses the pre-update counter value. The update still commits.
- Reset mid-operation: queue flushed, outstanding 0, err cleared, INIT re-entered. Table fully rewritten to 2'b11.

## Timing

- Table ready 2^INDEX_BITS cycles after rst deasserts. req_ready first high in the cycle after the last INIT write (cycle 2^INDEX_BITS+1 with rst low, counting from 1).
- Prediction latency: 1 cycle (accept edge → pred_valid high for exactly one cycle).
- Resolve-to-mispredict latency: 1 cycle. Counter update visible to requests accepted on the next edge onward.
- outstanding, full and req_ready are registered, updated on the edge of the push/pop.
- Sustained throughput: 1 request and 1 resolve per cycle.

## Test plan

- Reset, hold rst 2 cycles, release (INDEX_BITS=4) -> req_ready 0 for 16 cycles, then 1. Request index 5 -> next cycle pred_valid=1, pred_taken=1, pred_index=5.
- Two rounds on index 5, each: request, then resolve not-taken -> mispredict=1 on both resolves; counter 11→10→01. Third request index 5 -> pred_taken=0.
- Four requests, no resolves (DEPTH=4) -> outstanding=4, full=1, req_ready=0; fifth request not accepted. One resolve -> outstanding=3, req_ready=1 next cycle.
- Entry 3 at 2'b10 with a queued index-3 prediction; same-cycle resolve not-taken and new request index 3 -> new pred_taken=1 (old value); following request index 3 -> pred_taken=0.
- resolve_valid with outstanding=0 -> err=1 and stays 1; table contents unchanged. Resolve taken 5 times on an entry at 11 -> counter stays 11, mispredict=0.
- rst pulse with 2 predictions outstanding -> outstanding=0, err=0, req_ready=0 for 16 cycles. Every entry then predicts taken.
